// File: rtl/conv_pkg.sv
// Shared sizing and state encoding for the convolution result path.
// Frame order is flat index j = d*ROWS*COLS + r*COLS + c.
package conv_pkg;

    localparam int unsigned ROWS  = 6;
    localparam int unsigned COLS  = 6;
    localparam int unsigned CHANS = 3;
    localparam int unsigned DW    = 8;

    localparam int unsigned FRAME_ELEMS = ROWS * COLS * CHANS;
    localparam int unsigned FRAME_BITS  = FRAME_ELEMS * DW;

    localparam int unsigned CHAN_W = (CHANS > 1) ? $clog2(CHANS) : 1;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned IDX_W  = (FRAME_ELEMS > 1) ? $clog2(FRAME_ELEMS) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } stream_state_e;

endpackage

// File: rtl/conv_idx_counter.sv
// Nested (d,r,c) frame position counter with a matching flat index j.
// Wraps to the origin after the terminal position; clear has priority over enable.
module conv_idx_counter
    import conv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [CHAN_W-1:0] chan_o,
    output logic [ROW_W-1:0]  row_o,
    output logic [COL_W-1:0]  col_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              last_o
);

    localparam logic [CHAN_W-1:0] ChanMax = CHAN_W'(CHANS - 1);
    localparam logic [ROW_W-1:0]  RowMax  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  ColMax  = COL_W'(COLS - 1);

    logic [CHAN_W-1:0] chan_q, chan_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    assign last_o = (chan_q == ChanMax) && (row_q == RowMax) && (col_q == ColMax);

    always_comb begin
        chan_d = chan_q;
        row_d  = row_q;
        col_d  = col_q;
        idx_d  = idx_q;
        if (clr_i) begin
            chan_d = '0;
            row_d  = '0;
            col_d  = '0;
            idx_d  = '0;
        end else if (en_i) begin
            if (last_o) begin
                chan_d = '0;
                row_d  = '0;
                col_d  = '0;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + 1'b1;
                if (col_q == ColMax) begin
                    col_d = '0;
                    if (row_q == RowMax) begin
                        row_d  = '0;
                        chan_d = chan_q + 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            chan_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            idx_q  <= '0;
        end else begin
            chan_q <= chan_d;
            row_q  <= row_d;
            col_q  <= col_d;
            idx_q  <= idx_d;
        end
    end

    assign chan_o = chan_q;
    assign row_o  = row_q;
    assign col_o  = col_q;
    assign idx_o  = idx_q;

endmodule

// File: rtl/conv_result_streamer.sv
// Captures a whole convolution result frame in one cycle and replays it byte by byte
// on a valid/ready stream tagged with (chan,row,col) and a last flag.
module conv_result_streamer
    import conv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] conv_lin,
    input  logic                  conv_valid,
    output logic                  conv_ready,
    output logic [DW-1:0]         m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CHAN_W-1:0]     m_chan,
    output logic [ROW_W-1:0]      m_row,
    output logic [COL_W-1:0]      m_col,
    output logic                  m_last,
    output logic                  frame_done
);

    stream_state_e state_q, state_d;

    logic [FRAME_BITS-1:0] frame_q;
    logic                  frame_done_q;
    logic                  capture;
    logic                  accept;
    logic                  cnt_last;
    logic [IDX_W-1:0]      cnt_idx;
    logic [CHAN_W-1:0]     cnt_chan;
    logic [ROW_W-1:0]      cnt_row;
    logic [COL_W-1:0]      cnt_col;

    assign capture = (state_q == StIdle) && conv_valid;
    assign accept  = (state_q == StStream) && m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (conv_valid) state_d = StStream;
            StStream: if (m_ready && cnt_last) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        conv_ready = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        unique case (state_q)
            StIdle: conv_ready = 1'b1;
            StStream: begin
                m_valid = 1'b1;
                m_last  = cnt_last;
                m_data  = frame_q[cnt_idx * DW +: DW];
            end
            default: conv_ready = 1'b0;
        endcase
    end

    // Frame buffer carries no reset: its contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            frame_q <= conv_lin;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept && cnt_last;
        end
    end

    conv_idx_counter u_idx (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (capture),
        .en_i   (accept),
        .chan_o (cnt_chan),
        .row_o  (cnt_row),
        .col_o  (cnt_col),
        .idx_o  (cnt_idx),
        .last_o (cnt_last)
    );

    // Counter sits at the origin whenever idle, so tags read (0,0,0) there.
    assign m_chan     = cnt_chan;
    assign m_row      = cnt_row;
    assign m_col      = cnt_col;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed self-checking bench for conv_result_streamer.
module tb_conv_result_streamer;
    import conv_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [FRAME_BITS-1:0] conv_lin;
    logic                  conv_valid;
    logic                  conv_ready;
    logic [DW-1:0]         m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [CHAN_W-1:0]     m_chan;
    logic [ROW_W-1:0]      m_row;
    logic [COL_W-1:0]      m_col;
    logic                  m_last;
    logic                  frame_done;

    int passed = 0;
    int total  = 0;

    logic [7:0] exp_a [FRAME_ELEMS];
    logic [7:0] exp_b [FRAME_ELEMS];

    always #5 clk = ~clk;

    conv_result_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .conv_lin   (conv_lin),
        .conv_valid (conv_valid),
        .conv_ready (conv_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_chan     (m_chan),
        .m_row      (m_row),
        .m_col      (m_col),
        .m_last     (m_last),
        .frame_done (frame_done)
    );

    function automatic logic [FRAME_BITS-1:0] pack(input logic [7:0] f [FRAME_ELEMS]);
        logic [FRAME_BITS-1:0] v;
        for (int j = 0; j < FRAME_ELEMS; j++) v[j*8 +: 8] = f[j];
        return v;
    endfunction

    function automatic logic [7:0] tag_of(input int j);
        logic [1:0] d;
        logic [2:0] r;
        logic [2:0] c;
        d = 2'(j / 36);
        r = 3'((j % 36) / 6);
        c = 3'(j % 6);
        return {d, r, c};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; conv_valid = 1'b0; m_ready = 1'b0; conv_lin = '0;
        tick; tick;
        total++; if (conv_ready !== 1'b1) $display("FAIL reset_conv_ready got %b want 1", conv_ready); else passed++;
        total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else passed++;
        total++; if (m_last !== 1'b0) $display("FAIL reset_m_last got %b want 0", m_last); else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else passed++;
        total++; if ({m_chan, m_row, m_col} !== 8'h00) $display("FAIL reset_tags got %h want 00", {m_chan, m_row, m_col}); else passed++;
        total++; if (m_data !== 8'h00) $display("FAIL reset_m_data got %h want 00", m_data); else passed++;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_count_frame;
        for (int j = 0; j < FRAME_ELEMS; j++) exp_a[j] = 8'(j);
        conv_lin = pack(exp_a); conv_valid = 1'b1; m_ready = 1'b1;
        tick;
        conv_valid = 1'b0; conv_lin = '1;
        total++; if (conv_ready !== 1'b0) $display("FAIL count_conv_ready got %b want 0", conv_ready); else passed++;
        for (int b = 0; b < FRAME_ELEMS; b++) begin
            total++; if (m_valid !== 1'b1) $display("FAIL count_valid beat %0d got %b want 1", b, m_valid); else passed++;
            total++; if (m_data !== exp_a[b]) $display("FAIL count_data beat %0d got %h want %h", b, m_data, exp_a[b]); else passed++;
            total++; if ({m_chan, m_row, m_col} !== tag_of(b)) $display("FAIL count_tags beat %0d got %h want %h", b, {m_chan, m_row, m_col}, tag_of(b)); else passed++;
            total++; if (m_last !== (b == FRAME_ELEMS - 1)) $display("FAIL count_last beat %0d got %b", b, m_last); else passed++;
            total++; if (frame_done !== 1'b0) $display("FAIL count_early_done beat %0d got %b want 0", b, frame_done); else passed++;
            tick;
        end
        total++; if (frame_done !== 1'b1) $display("FAIL count_frame_done got %b want 1", frame_done); else passed++;
        total++; if (m_valid !== 1'b0) $display("FAIL count_idle_valid got %b want 0", m_valid); else passed++;
        total++; if (conv_ready !== 1'b1) $display("FAIL count_idle_ready got %b want 1", conv_ready); else passed++;
        tick;
        total++; if (frame_done !== 1'b0) $display("FAIL count_done_pulse got %b want 0", frame_done); else passed++;
    endtask

    task automatic test_signed;
        for (int j = 0; j < FRAME_ELEMS; j++) exp_a[j] = 8'h00;
        exp_a[0] = 8'h80; exp_a[35] = 8'hFF; exp_a[107] = 8'h7F;
        conv_lin = pack(exp_a); conv_valid = 1'b1; m_ready = 1'b1;
        tick;
        conv_valid = 1'b0;
        for (int b = 0; b < FRAME_ELEMS; b++) begin
            total++; if (m_data !== exp_a[b]) $display("FAIL signed_data beat %0d got %h want %h", b, m_data, exp_a[b]); else passed++;
            if (b == 35) begin
                total++; if ({m_chan, m_row, m_col} !== {2'd0, 3'd5, 3'd5}) $display("FAIL signed_tag35 got %h want 2d", {m_chan, m_row, m_col}); else passed++;
            end
            if (b == 36) begin
                total++; if ({m_chan, m_row, m_col} !== {2'd1, 3'd0, 3'd0}) $display("FAIL signed_tag36 got %h want 40", {m_chan, m_row, m_col}); else passed++;
            end
            tick;
        end
        total++; if (frame_done !== 1'b1) $display("FAIL signed_frame_done got %b want 1", frame_done); else passed++;
    endtask

    task automatic test_backpressure;
        int         b = 0;
        int         cyc = 0;
        int         stall = 0;
        logic       held_ok = 1'b0;
        logic [16:0] held;
        for (int j = 0; j < FRAME_ELEMS; j++) exp_a[j] = 8'(j) ^ 8'h5A;
        conv_lin = pack(exp_a); conv_valid = 1'b1; m_ready = 1'b1;
        tick;
        conv_valid = 1'b0;
        while (b < FRAME_ELEMS && cyc < 2000) begin
            total++; if (m_valid !== 1'b1) $display("FAIL bp_valid beat %0d got %b want 1", b, m_valid); else passed++;
            total++; if (m_data !== exp_a[b]) $display("FAIL bp_data beat %0d got %h want %h", b, m_data, exp_a[b]); else passed++;
            total++; if ({m_chan, m_row, m_col} !== tag_of(b)) $display("FAIL bp_tags beat %0d got %h want %h", b, {m_chan, m_row, m_col}, tag_of(b)); else passed++;
            total++; if (m_last !== (b == FRAME_ELEMS - 1)) $display("FAIL bp_last beat %0d got %b", b, m_last); else passed++;
            if (held_ok) begin
                total++; if ({m_data, m_chan, m_row, m_col, m_last} !== held) $display("FAIL bp_hold beat %0d got %h want %h", b, {m_data, m_chan, m_row, m_col, m_last}, held); else passed++;
            end
            if (b == 17 && stall < 5) begin
                m_ready = 1'b0;
                stall++;
            end else begin
                m_ready = 1'($urandom_range(1, 0));
            end
            held    = {m_data, m_chan, m_row, m_col, m_last};
            held_ok = !m_ready;
            tick;
            cyc++;
            if (m_ready) b++;
        end
        total++; if (b != FRAME_ELEMS) $display("FAIL bp_timeout got %0d beats want %0d", b, FRAME_ELEMS); else passed++;
        total++; if (stall != 5) $display("FAIL bp_stall_count got %0d want 5", stall); else passed++;
        total++; if (frame_done !== 1'b1) $display("FAIL bp_frame_done got %b want 1", frame_done); else passed++;
        m_ready = 1'b1;
    endtask

    task automatic test_overlap;
        for (int j = 0; j < FRAME_ELEMS; j++) begin
            exp_a[j] = 8'(255 - j);
            exp_b[j] = 8'hAA;
        end
        conv_lin = pack(exp_a); conv_valid = 1'b1; m_ready = 1'b1;
        tick;
        conv_valid = 1'b0;
        for (int b = 0; b < FRAME_ELEMS; b++) begin
            if (b == 10) begin
                conv_lin = pack(exp_b);
                conv_valid = 1'b1;
            end
            if (b >= 10) begin
                total++; if (conv_ready !== 1'b0) $display("FAIL ovl_ready beat %0d got %b want 0", b, conv_ready); else passed++;
            end
            total++; if (m_data !== exp_a[b]) $display("FAIL ovl_data beat %0d got %h want %h", b, m_data, exp_a[b]); else passed++;
            tick;
        end
        total++; if (frame_done !== 1'b1) $display("FAIL ovl_frame_done got %b want 1", frame_done); else passed++;
        total++; if (conv_ready !== 1'b1) $display("FAIL ovl_ready_done got %b want 1", conv_ready); else passed++;
        tick;
        conv_valid = 1'b0;
        for (int b = 0; b < FRAME_ELEMS; b++) begin
            total++; if (m_valid !== 1'b1 || m_data !== 8'hAA) $display("FAIL ovl_second beat %0d got v=%b d=%h want v=1 d=aa", b, m_valid, m_data); else passed++;
            tick;
        end
        total++; if (frame_done !== 1'b1) $display("FAIL ovl_second_done got %b want 1", frame_done); else passed++;
    endtask

    task automatic test_back_to_back;
        for (int j = 0; j < FRAME_ELEMS; j++) begin
            exp_a[j] = 8'(j) ^ 8'h3C;
            exp_b[j] = 8'(j + 100);
        end
        conv_lin = pack(exp_a); conv_valid = 1'b1; m_ready = 1'b1;
        tick;
        conv_lin = pack(exp_b);
        for (int b = 0; b < FRAME_ELEMS; b++) begin
            total++; if (m_data !== exp_a[b]) $display("FAIL b2b_first beat %0d got %h want %h", b, m_data, exp_a[b]); else passed++;
            tick;
        end
        total++; if (m_valid !== 1'b0) $display("FAIL b2b_bubble_valid got %b want 0", m_valid); else passed++;
        total++; if (conv_ready !== 1'b1 || frame_done !== 1'b1) $display("FAIL b2b_bubble got ready=%b done=%b want 1 1", conv_ready, frame_done); else passed++;
        tick;
        conv_valid = 1'b0;
        total++; if (m_valid !== 1'b1 || {m_chan, m_row, m_col} !== 8'h00) $display("FAIL b2b_restart got v=%b tags=%h want v=1 tags=00", m_valid, {m_chan, m_row, m_col}); else passed++;
        for (int b = 0; b < FRAME_ELEMS; b++) begin
            total++; if (m_data !== exp_b[b]) $display("FAIL b2b_second beat %0d got %h want %h", b, m_data, exp_b[b]); else passed++;
            tick;
        end
        total++; if (frame_done !== 1'b1) $display("FAIL b2b_second_done got %b want 1", frame_done); else passed++;
    endtask

    task automatic test_mid_reset;
        for (int j = 0; j < FRAME_ELEMS; j++) begin
            exp_a[j] = 8'(j) ^ 8'hC3;
            exp_b[j] = ~8'(j);
        end
        conv_lin = pack(exp_a); conv_valid = 1'b1; m_ready = 1'b1;
        tick;
        conv_valid = 1'b0;
        for (int b = 0; b < 50; b++) tick;
        total++; if (m_data !== exp_a[50] || {m_chan, m_row, m_col} !== tag_of(50)) $display("FAIL rst_beat50 got d=%h t=%h want d=%h t=%h", m_data, {m_chan, m_row, m_col}, exp_a[50], tag_of(50)); else passed++;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        total++; if (m_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", m_valid); else passed++;
        total++; if (conv_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", conv_ready); else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL rst_done got %b want 0", frame_done); else passed++;
        tick;
        total++; if (frame_done !== 1'b0 || m_valid !== 1'b0) $display("FAIL rst_after got done=%b v=%b want 0 0", frame_done, m_valid); else passed++;
        conv_lin = pack(exp_b); conv_valid = 1'b1;
        tick;
        conv_valid = 1'b0;
        total++; if ({m_chan, m_row, m_col} !== 8'h00) $display("FAIL rst_restart_tags got %h want 00", {m_chan, m_row, m_col}); else passed++;
        for (int b = 0; b < FRAME_ELEMS; b++) begin
            total++; if (m_data !== exp_b[b]) $display("FAIL rst_new_data beat %0d got %h want %h", b, m_data, exp_b[b]); else passed++;
            tick;
        end
        total++; if (frame_done !== 1'b1) $display("FAIL rst_new_done got %b want 1", frame_done); else passed++;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count_frame();
        test_signed();
        test_backpressure();
        test_overlap();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
